// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared constants, mode encodings and the controller
// state type for the counter sequencer.
package counter_seq_pkg;

    // Default datapath geometry
    localparam int DEF_WIDTH  = 3;
    localparam int DEF_STEP_W = 4;

    // Command mode encodings (2'b11 is folded onto MODE_UP)
    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Map a raw command mode onto one of the three supported modes
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        logic [1:0] m;
        case (mode)
            MODE_UP:     m = MODE_UP;
            MODE_DOWN:   m = MODE_DOWN;
            MODE_BOUNCE: m = MODE_BOUNCE;
            default:     m = MODE_UP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/counter_seq_dir.sv
// counter_seq_dir: combinational stepping rule for the sequencer.
// Given the mode, the stored bounce direction and the current count it
// returns the effective (post-flip) direction of the step taken from this
// count, the count after that step, and the effective direction of the
// step after it. The last output lets the controller register cnt_up one
// full cycle ahead of the edge that uses it.
module counter_seq_dir
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] count,
    output logic             eff_dir,
    output logic [WIDTH-1:0] next_count,
    output logic             next_dir
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MIN = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1'b1);

    // Direction of the step leaving the current count (bounce flips at the ends)
    always_comb begin
        eff_dir = 1'b1;
        case (mode)
            MODE_UP: begin
                eff_dir = 1'b1;
            end
            MODE_DOWN: begin
                eff_dir = 1'b0;
            end
            MODE_BOUNCE: begin
                if (dir && (count == CNT_MAX)) begin
                    eff_dir = 1'b0;
                end else if (!dir && (count == CNT_MIN)) begin
                    eff_dir = 1'b1;
                end else begin
                    eff_dir = dir;
                end
            end
            default: begin
                eff_dir = 1'b1;
            end
        endcase
    end

    // Count after one step, modulo 2^WIDTH
    always_comb begin
        next_count = count;
        if (eff_dir) begin
            next_count = count + CNT_ONE;
        end else begin
            next_count = count - CNT_ONE;
        end
    end

    // Direction of the following step, seen from the post-step count
    always_comb begin
        next_dir = 1'b1;
        case (mode)
            MODE_UP: begin
                next_dir = 1'b1;
            end
            MODE_DOWN: begin
                next_dir = 1'b0;
            end
            MODE_BOUNCE: begin
                if (eff_dir && (next_count == CNT_MAX)) begin
                    next_dir = 1'b0;
                end else if (!eff_dir && (next_count == CNT_MIN)) begin
                    next_dir = 1'b1;
                end else begin
                    next_dir = eff_dir;
                end
            end
            default: begin
                next_dir = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: command-driven sequencer for the up/down counter.
// Accepts (mode, steps) over valid/ready and issues exactly that many
// registered enable pulses with a registered direction, while keeping a
// shadow copy of the count. Optional feature macro: COUNTER_SEQ_PAUSE_EN
// (adds the pause input that holds stepping during RUN).
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [STEP_W-1:0] cmd_steps,
`ifdef COUNTER_SEQ_PAUSE_EN
    input  logic              pause,
`endif
    output logic              cnt_en,
    output logic              cnt_up,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done
);

    localparam logic [STEP_W-1:0] STEPS_ZERO = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] STEPS_ONE  = STEP_W'(1'b1);
    localparam logic [WIDTH-1:0]  CNT_ZERO   = {WIDTH{1'b0}};

    state_t            state_r;
    logic [1:0]        mode_r;
    logic [STEP_W-1:0] steps_left_r;
    logic              dir_r;
    logic [WIDTH-1:0]  count_r;
    logic              cnt_en_r;
    logic              cnt_up_r;
    logic              busy_r;
    logic              done_r;
    logic              cmd_ready_r;

    logic              pause_s;
    logic              accept_s;
    logic [1:0]        dir_mode_s;
    logic              eff_dir_s;
    logic [WIDTH-1:0]  next_count_s;
    logic              next_dir_s;

`ifdef COUNTER_SEQ_PAUSE_EN
    assign pause_s = pause;
`else
    assign pause_s = 1'b0;
`endif

    assign accept_s = cmd_valid & cmd_ready_r;

    // In IDLE the stepping rule looks at the incoming command so the first
    // cnt_up is right on the accepting edge; afterwards it uses the latched mode
    always_comb begin
        dir_mode_s = mode_r;
        if (state_r == IDLE) begin
            dir_mode_s = norm_mode(cmd_mode);
        end else begin
            dir_mode_s = mode_r;
        end
    end

    counter_seq_dir #(
        .WIDTH (WIDTH)
    ) u_dir (
        .mode       (dir_mode_s),
        .dir        (dir_r),
        .count      (count_r),
        .eff_dir    (eff_dir_s),
        .next_count (next_count_s),
        .next_dir   (next_dir_s)
    );

    // Controller FSM: all outputs registered. A step happens on every edge
    // that sees cnt_en_r high, so the shadow count moves on exactly the same
    // edges as the external counter.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r      <= IDLE;
            mode_r       <= MODE_UP;
            steps_left_r <= STEPS_ZERO;
            dir_r        <= 1'b1;
            count_r      <= CNT_ZERO;
            cnt_en_r     <= 1'b0;
            cnt_up_r     <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            cmd_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        mode_r       <= norm_mode(cmd_mode);
                        steps_left_r <= cmd_steps;
                        busy_r       <= 1'b1;
                        cmd_ready_r  <= 1'b0;
                        if (cmd_steps != STEPS_ZERO) begin
                            state_r  <= RUN;
                            cnt_en_r <= 1'b1;
                            cnt_up_r <= eff_dir_s;
                        end else begin
                            state_r  <= DONE;
                            cnt_en_r <= 1'b0;
                            done_r   <= 1'b1;
                        end
                    end else begin
                        busy_r      <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        cnt_en_r    <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt_en_r) begin
                        // the counter steps on this edge; mirror it
                        count_r      <= next_count_s;
                        steps_left_r <= steps_left_r - STEPS_ONE;
                        if (mode_r == MODE_BOUNCE) begin
                            dir_r <= eff_dir_s;
                        end else begin
                            dir_r <= dir_r;
                        end
                        if (steps_left_r == STEPS_ONE) begin
                            state_r  <= DONE;
                            cnt_en_r <= 1'b0;
                            done_r   <= 1'b1;
                        end else begin
                            cnt_en_r <= ~pause_s;
                            cnt_up_r <= next_dir_s;
                        end
                    end else begin
                        // paused cycle: nothing moves, just re-arm
                        cnt_en_r <= ~pause_s;
                        cnt_up_r <= eff_dir_s;
                    end
                end
                DONE: begin
                    state_r     <= IDLE;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    cnt_en_r    <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    cnt_en_r    <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_en    = cnt_en_r;
    assign cnt_up    = cnt_up_r;
    assign count     = count_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cmd_ready = cmd_ready_r;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed self-checking bench for counter_seq_ctrl
// (WIDTH=3, STEP_W=4). Pause scenario is built only with COUNTER_SEQ_PAUSE_EN.
module tb_counter_seq_ctrl;

    localparam int WIDTH  = 3;
    localparam int STEP_W = 4;

    logic              clock = 1'b0;
    logic              clear = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_mode = 2'b00;
    logic [STEP_W-1:0] cmd_steps = 4'd0;
`ifdef COUNTER_SEQ_PAUSE_EN
    logic              pause = 1'b0;
`endif
    logic              cnt_en;
    logic              cnt_up;
    logic [WIDTH-1:0]  count;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    // bounce scenario: count before each step and direction of that step
    int bounce_cnt [12] = '{5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    int bounce_dir [12] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    int down_cnt   [3]  = '{1, 0, 7};

    always #5 clock = ~clock;

    counter_seq_ctrl #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_steps (cmd_steps),
`ifdef COUNTER_SEQ_PAUSE_EN
        .pause     (pause),
`endif
        .cnt_en    (cnt_en),
        .cnt_up    (cnt_up),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // issue one command from IDLE and wait (bounded) for its done pulse
    task automatic run_cmd(input logic [1:0] mode, input logic [STEP_W-1:0] steps, input string tag);
        logic seen;
        seen = 1'b0;
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_steps = steps;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else tick();
        end
        chk(tag, {31'd0, seen}, 32'd1);
        tick();
    endtask

    initial begin
        // ---- reset ----
        tick();
        tick();
        clear = 1'b0;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_cnt_en", {31'd0, cnt_en}, 32'd0);
        chk("rst_cnt_up", {31'd0, cnt_up}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // ---- up-wrap, 10 steps from 0 ----
        cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_steps = 4'd10;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("up_en", {31'd0, cnt_en}, 32'd1);
            chk("up_dir", {31'd0, cnt_up}, 32'd1);
            chk("up_count", {29'd0, count}, i % 8);
            chk("up_ready", {31'd0, cmd_ready}, 32'd0);
            chk("up_nodone", {31'd0, done}, 32'd0);
            tick();
        end
        chk("up_done", {31'd0, done}, 32'd1);
        chk("up_en_off", {31'd0, cnt_en}, 32'd0);
        chk("up_final", {29'd0, count}, 32'd2);
        chk("up_busy_done", {31'd0, busy}, 32'd1);
        chk("up_ready_done", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("up_done_pulse", {31'd0, done}, 32'd0);
        chk("up_ready_back", {31'd0, cmd_ready}, 32'd1);
        chk("up_busy_off", {31'd0, busy}, 32'd0);

        // ---- down-wrap, 3 steps from 1 ----
        run_cmd(2'b01, 4'd1, "prep_down");
        chk("prep_down_count", {29'd0, count}, 32'd1);
        cmd_valid = 1'b1; cmd_mode = 2'b01; cmd_steps = 4'd3;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("down_en", {31'd0, cnt_en}, 32'd1);
            chk("down_dir", {31'd0, cnt_up}, 32'd0);
            chk("down_count", {29'd0, count}, down_cnt[i]);
            tick();
        end
        chk("down_done", {31'd0, done}, 32'd1);
        chk("down_final", {29'd0, count}, 32'd6);
        tick();

        // ---- bounce, 12 steps from 5, direction up ----
        run_cmd(2'b01, 4'd1, "prep_bounce");
        chk("prep_bounce_count", {29'd0, count}, 32'd5);
        cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_steps = 4'd12;
        tick();
        cmd_valid = 1'b0;
        for (int j = 0; j < 12; j++) begin
            chk("bnc_en", {31'd0, cnt_en}, 32'd1);
            chk("bnc_dir", {31'd0, cnt_up}, bounce_dir[j]);
            chk("bnc_count", {29'd0, count}, bounce_cnt[j]);
            tick();
        end
        chk("bnc_done", {31'd0, done}, 32'd1);
        chk("bnc_final", {29'd0, count}, 32'd3);
        tick();

        // ---- zero steps, then a command held while busy (mode 11 = up) ----
        cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_steps = 4'd0;
        tick();
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_en", {31'd0, cnt_en}, 32'd0);
        chk("zero_busy", {31'd0, busy}, 32'd1);
        chk("zero_ready", {31'd0, cmd_ready}, 32'd0);
        chk("zero_count", {29'd0, count}, 32'd3);
        cmd_mode = 2'b11; cmd_steps = 4'd2;
        tick();
        chk("held_not_taken", {31'd0, cnt_en}, 32'd0);
        chk("held_done_off", {31'd0, done}, 32'd0);
        chk("held_ready", {31'd0, cmd_ready}, 32'd1);
        chk("held_busy", {31'd0, busy}, 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("held_en", {31'd0, cnt_en}, 32'd1);
        chk("held_dir", {31'd0, cnt_up}, 32'd1);
        chk("held_count0", {29'd0, count}, 32'd3);
        tick();
        chk("held_count1", {29'd0, count}, 32'd4);
        tick();
        chk("held_done", {31'd0, done}, 32'd1);
        chk("held_count2", {29'd0, count}, 32'd5);
        tick();

        // ---- bounce direction persists across commands ----
        run_cmd(2'b10, 4'd3, "persist_a");
        chk("persist_a_count", {29'd0, count}, 32'd6);
        cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_steps = 4'd2;
        tick();
        cmd_valid = 1'b0;
        chk("persist_dir", {31'd0, cnt_up}, 32'd0);
        tick();
        tick();
        chk("persist_done", {31'd0, done}, 32'd1);
        chk("persist_count", {29'd0, count}, 32'd4);
        tick();

        // ---- clear in the 4th cycle of RUN ----
        cmd_valid = 1'b1; cmd_mode = 2'b01; cmd_steps = 4'd8;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("clr_pre_count", {29'd0, count}, 32'd1);
        chk("clr_pre_en", {31'd0, cnt_en}, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_count", {29'd0, count}, 32'd0);
        chk("clr_ready", {31'd0, cmd_ready}, 32'd1);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_en", {31'd0, cnt_en}, 32'd0);
        chk("clr_dir", {31'd0, cnt_up}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("clr_no_done", {31'd0, done}, 32'd0);
            tick();
        end
        // clear also restores the bounce direction to up
        run_cmd(2'b00, 4'd3, "post_clr_up");
        chk("post_clr_count", {29'd0, count}, 32'd3);
        cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_steps = 4'd1;
        tick();
        cmd_valid = 1'b0;
        chk("clr_bnc_dir", {31'd0, cnt_up}, 32'd1);
        tick();
        chk("clr_bnc_done", {31'd0, done}, 32'd1);
        chk("clr_bnc_count", {29'd0, count}, 32'd4);
        tick();

`ifdef COUNTER_SEQ_PAUSE_EN
        // ---- pause for 3 cycles during an up-wrap of 5 steps from 4 ----
        begin
            int en_cyc;
            int lo_cyc;
            int idx;
            en_cyc = 0;
            lo_cyc = 0;
            idx    = 0;
            cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_steps = 4'd5;
            tick();
            cmd_valid = 1'b0;
            while (done !== 1'b1 && idx < 40) begin
                if (cnt_en === 1'b1) en_cyc++;
                else lo_cyc++;
                pause = (idx >= 1 && idx <= 3);
                tick();
                idx++;
            end
            pause = 1'b0;
            chk("pause_done_seen", {31'd0, done}, 32'd1);
            chk("pause_done_cycle", idx, 32'd8);
            chk("pause_en_cycles", en_cyc, 32'd5);
            chk("pause_lo_cycles", lo_cyc, 32'd3);
            chk("pause_final", {29'd0, count}, 32'd1);
            tick();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
